param_counter: RTL and testbench
================================

PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter PRESCALE, default 4: prescale ratio, legal range 2..256; used only when COUNTER_PRESCALE_EN is defined.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  count enable; a step is taken only when en=1.
REQ-006 load  input  1  synchronous load strobe.
REQ-007 load_val  input  WIDTH  value loaded when load=1.
REQ-008 up_dn  input  1  direction: 1=up, 0=down.
REQ-009 mode  input  2  00=wrap, 01=saturate, 10=one-shot, 11=reserved (the block treats it as wrap).
REQ-010 limit  input  WIDTH  terminal value when counting up; wrap target when counting down.
REQ-011 count  output  WIDTH  registered counter state.
REQ-012 tc  output  1  registered terminal-count pulse.
REQ-013 done  output  1  registered one-shot completion flag.

Function
REQ-014 Priority per edge: reset > load > step > hold.
REQ-015 Load: count<=load_val, done<=0, tc<=0, regardless of en, mode and done.
REQ-016 A step occurs when en=1, load=0 and done=0 (and, with prescaler, on a prescale tick).
REQ-017 Up step: if count>=limit, the step is terminal; otherwise count<=count+1.
REQ-018 Down step: if count==0, the step is terminal; otherwise count<=count-1.
REQ-019 Terminal up step: wrap gives count<=0; saturate and one-shot hold count.
REQ-020 Terminal down step: wrap gives count<=limit; saturate and one-shot hold count.
REQ-021 One-shot terminal step sets done<=1; further steps are blocked until load or reset.
REQ-022 tc<=1 for exactly one cycle on the edge where a non-terminal step makes count equal limit (up) or 0 (down); tc=0 on all other edges, including saturated holds and loads.
REQ-023 A loaded count above limit while counting up is terminal on the next step: wrap->0, saturate and one-shot hold; no tc is asserted.
REQ-024 limit=0 in wrap mode: count stays 0 and tc never asserts.
REQ-025 Changes to up_dn, mode or limit take effect on the next step; no pipeline delay.
REQ-026 All arithmetic is modulo 2^WIDTH; count never takes an intermediate or glitch value.

Reset
REQ-027 While rst_n=0 at an edge: count<=0, tc<=0, done<=0, prescaler<=0.
REQ-028 Reset mid-count or mid-one-shot discards all state; the first step after release starts from 0.

Configuration
REQ-029 Macro COUNTER_PRESCALE_EN defined: an internal prescaler counts 0..PRESCALE-1 on cycles with en=1, load=0 and done=0; a step is taken only on the cycle it equals PRESCALE-1, and it then wraps to 0.
REQ-030 With COUNTER_PRESCALE_EN, load and reset clear the prescaler; en=0 freezes it.
REQ-031 Macro undefined: no prescaler logic is built; every qualifying cycle steps; PRESCALE is ignored.

Verification
REQ-032 WIDTH=8, wrap, up, limit=5, en=1 from reset: count 0,1,2,3,4,5,0,1; tc high only on the cycle count first shows 5.
REQ-033 Saturate, down, load_val=3 then en=1: count 3,2,1,0,0,0; tc high once, on arrival at 0.
REQ-034 One-shot, up, limit=3, from 0: count reaches 3, done=1, count holds; load=1 with load_val=1 gives count=1, done=0 and counting resumes.
REQ-035 load=1 and en=1 in the same cycle at count=limit: count=load_val, tc=0; rst_n=0 mid-count gives count=0, done=0 on the next edge.
REQ-036 COUNTER_PRESCALE_EN with PRESCALE=4, wrap, up: count increments every 4th en cycle; en low for 2 cycles stretches the interval to 6.

Source files
------------

// File: rtl/param_counter.sv
// param_counter: up/down counter with wrap, saturate and one-shot modes.
// Reset is synchronous and active-low (rst_n). tc and done are registered.
// Optional prescaler: define COUNTER_PRESCALE_EN so that a step happens only on
// every PRESCALE-th qualifying cycle. With the macro undefined the prescaler is
// not built and every qualifying cycle steps.
module param_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SAT      = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;
  localparam logic [1:0] MODE_RESERVED = 2'b11;

  // Legal parameter window; an out-of-range build never steps.
  localparam bit CFG_OK = (WIDTH >= 2) && (WIDTH <= 32) &&
                          (PRESCALE >= 2) && (PRESCALE <= 256);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_count_next;
  logic             r_tc;
  logic             r_tc_next;
  logic             r_done;
  logic             r_done_next;

  logic             w_qualify;
  logic             w_tick;
  logic             w_step;
  logic             w_term;
  logic             w_wrap_mode;
  logic             w_oneshot_mode;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  // A cycle qualifies for counting (and for advancing the prescaler) only
  // when enabled, not loading and not parked in one-shot completion.
  assign w_qualify = en & ~load & ~r_done;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PW      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_ps;

  // Prescaler: free-runs 0..PRESCALE-1 on qualifying cycles; load/reset clear it.
  always_ff @(posedge clk) begin
    if (!rst_n || load) begin
      r_ps <= '0;
    end else if (w_qualify) begin
      r_ps <= (r_ps == PS_LAST) ? '0 : r_ps + PW'(1);
    end
  end

  assign w_tick = CFG_OK && (r_ps == PS_LAST);
`else
  assign w_tick = CFG_OK;
`endif

  assign w_step         = w_qualify & w_tick;
  assign w_inc          = r_count + WIDTH'(1);
  assign w_dec          = r_count - WIDTH'(1);
  assign w_wrap_mode    = (mode == MODE_WRAP) || (mode == MODE_RESERVED);
  assign w_oneshot_mode = (mode == MODE_ONESHOT);
  // Up: at or beyond limit is terminal (covers a load above limit).
  assign w_term         = up_dn ? (r_count >= limit) : (r_count == '0);

  // Next-state: load beats step beats hold; tc only on a non-terminal arrival.
  always_comb begin
    r_count_next = r_count;
    r_done_next  = r_done;
    r_tc_next    = 1'b0;
    if (load) begin
      r_count_next = load_val;
      r_done_next  = 1'b0;
    end else if (w_step) begin
      if (w_term) begin
        if (w_wrap_mode) begin
          r_count_next = up_dn ? '0 : limit;
        end else if (w_oneshot_mode) begin
          r_done_next = 1'b1;
        end
        // MODE_SAT holds count with no flag.
      end else if (up_dn) begin
        r_count_next = w_inc;
        r_tc_next    = (w_inc == limit);
      end else begin
        r_count_next = w_dec;
        r_tc_next    = (w_dec == '0);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= r_count_next;
      r_tc    <= r_tc_next;
      r_done  <= r_done_next;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign done  = r_done;

  // MODE_SAT is named for readability; saturate is the default hold path.
  logic w_unused_sat;
  assign w_unused_sat = (mode == MODE_SAT);

endmodule

// File: tb/tb_param_counter.sv
// Testbench for param_counter (WIDTH=8). Directed scenarios plus a randomized
// run checked against an integer reference model of the counter rules.
// Build with COUNTER_PRESCALE_EN defined to exercise the prescaler scenario.
module tb_param_counter;

  localparam int W = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic         up_dn;
  logic [1:0]   mode;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         tc;
  logic         done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (plain integers).
  int m_count = 0;
  int m_tc    = 0;
  int m_done  = 0;
  int m_ps    = 0;

  param_counter #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .load_val(load_val),
    .up_dn(up_dn), .mode(mode), .limit(limit),
    .count(count), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  // Apply the counter rules for one rising edge to the model.
  task automatic model_update();
    bit tick;
    bit wrapm;
    wrapm = (mode == 2'b00) || (mode == 2'b11);
    if (!rst_n) begin
      m_count = 0; m_tc = 0; m_done = 0; m_ps = 0;
    end else if (load) begin
      m_count = int'(load_val); m_tc = 0; m_done = 0; m_ps = 0;
    end else begin
      m_tc = 0;
      if (en && m_done == 0) begin
        tick = 1'b1;
`ifdef COUNTER_PRESCALE_EN
        if (m_ps == P - 1) m_ps = 0;
        else begin m_ps = m_ps + 1; tick = 1'b0; end
`endif
        if (tick) begin
          if (up_dn) begin
            if (m_count >= int'(limit)) begin
              if (wrapm) m_count = 0;
              else if (mode == 2'b10) m_done = 1;
            end else begin
              m_count = m_count + 1;
              m_tc = (m_count == int'(limit)) ? 1 : 0;
            end
          end else begin
            if (m_count == 0) begin
              if (wrapm) m_count = int'(limit);
              else if (mode == 2'b10) m_done = 1;
            end else begin
              m_count = m_count - 1;
              m_tc = (m_count == 0) ? 1 : 0;
            end
          end
        end
      end
    end
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; load = 0; load_val = '0; up_dn = 1; mode = 2'b00; limit = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    cycle(); cycle();
    n_tests++;
    if (count !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: count=%0d tc=%b done=%b required 0/0/0", count, tc, done);
    end
    rst_n = 1;
    cycle();
    n_tests++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_release_hold: count=%0d required 0", count);
    end
    $display("[TB] test_reset done");
  endtask

`ifndef COUNTER_PRESCALE_EN
  task automatic test_wrap_up();
    int exp_c[7];
    int exp_t[7];
    exp_c = '{1, 2, 3, 4, 5, 0, 1};
    exp_t = '{0, 0, 0, 0, 1, 0, 0};
    rst_n = 0; cycle(); rst_n = 1;
    mode = 2'b00; up_dn = 1; limit = 8'd5; en = 1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      n_tests++;
      if (count !== W'(exp_c[i]) || tc !== exp_t[i][0]) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: count=%0d tc=%b required %0d/%0d", i, count, tc, exp_c[i], exp_t[i]);
      end
      $display("[TB] wrap_up step %0d count=%0d tc=%b", i, count, tc);
    end
    en = 0;
  endtask

  task automatic test_saturate_down();
    int exp_c[5];
    int exp_t[5];
    exp_c = '{2, 1, 0, 0, 0};
    exp_t = '{0, 0, 1, 0, 0};
    mode = 2'b01; up_dn = 0; limit = 8'd9;
    load = 1; load_val = 8'd3; en = 0;
    cycle();
    load = 0;
    n_tests++;
    if (count !== 8'd3 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load: count=%0d tc=%b required 3/0", count, tc);
    end
    en = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_tests++;
      if (count !== W'(exp_c[i]) || tc !== exp_t[i][0]) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: count=%0d tc=%b required %0d/%0d", i, count, tc, exp_c[i], exp_t[i]);
      end
      $display("[TB] sat_down step %0d count=%0d tc=%b", i, count, tc);
    end
    en = 0;
  endtask

  task automatic test_oneshot();
    rst_n = 0; cycle(); rst_n = 1;
    mode = 2'b10; up_dn = 1; limit = 8'd3; en = 1;
    cycle(); cycle(); cycle();
    n_tests++;
    if (count !== 8'd3 || tc !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_arrive: count=%0d tc=%b done=%b required 3/1/0", count, tc, done);
    end
    cycle();
    n_tests++;
    if (count !== 8'd3 || tc !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_done: count=%0d tc=%b done=%b required 3/0/1", count, tc, done);
    end
    limit = 8'd20;  // even a larger limit must not resume a finished one-shot
    cycle(); cycle();
    n_tests++;
    if (count !== 8'd3 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL oneshot_hold: count=%0d done=%b required 3/1", count, done);
    end
    load = 1; load_val = 8'd1;
    cycle();
    load = 0;
    n_tests++;
    if (count !== 8'd1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL oneshot_reload: count=%0d done=%b required 1/0", count, done);
    end
    cycle();
    n_tests++;
    if (count !== 8'd2) begin
      n_fail++;
      $display("FAIL oneshot_resume: count=%0d required 2", count);
    end
    $display("[TB] oneshot count=%0d done=%b", count, done);
    en = 0;
  endtask

  task automatic test_back_to_back();
    rst_n = 0; cycle(); rst_n = 1;
    mode = 2'b00; up_dn = 1; limit = 8'd5; en = 1;
    repeat (5) cycle();
    load = 1; load_val = 8'hA7;
    cycle();
    load = 0;
    n_tests++;
    if (count !== 8'hA7 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL load_over_step: count=%0d tc=%b required 167/0", count, tc);
    end
    cycle();
    n_tests++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL above_limit_wrap: count=%0d tc=%b required 0/0", count, tc);
    end
    cycle(); cycle();
    rst_n = 0;
    cycle();
    rst_n = 1;
    n_tests++;
    if (count !== 8'd0 || done !== 1'b0 || tc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_count: count=%0d done=%b tc=%b required 0/0/0", count, done, tc);
    end
    cycle();
    n_tests++;
    if (count !== 8'd1) begin
      n_fail++;
      $display("FAIL restart_from_zero: count=%0d required 1", count);
    end
    $display("[TB] back_to_back count=%0d", count);
    en = 0;
  endtask

  task automatic test_limit_zero();
    rst_n = 0; cycle(); rst_n = 1;
    mode = 2'b00; up_dn = 1; limit = 8'd0; en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_tests++;
      if (count !== 8'd0 || tc !== 1'b0) begin
        n_fail++;
        $display("FAIL limit_zero[%0d]: count=%0d tc=%b required 0/0", i, count, tc);
      end
    end
    $display("[TB] limit_zero count=%0d", count);
    en = 0;
  endtask
`else
  task automatic test_prescale();
    rst_n = 0; cycle(); rst_n = 1;
    mode = 2'b00; up_dn = 1; limit = 8'd200; en = 1;
    repeat (3) cycle();
    n_tests++;
    if (count !== 8'd0) begin
      n_fail++;
      $display("FAIL prescale_early: count=%0d required 0", count);
    end
    cycle();
    n_tests++;
    if (count !== 8'd1) begin
      n_fail++;
      $display("FAIL prescale_first: count=%0d required 1", count);
    end
    cycle(); en = 0; cycle(); cycle(); en = 1;
    cycle(); cycle();
    n_tests++;
    if (count !== 8'd1) begin
      n_fail++;
      $display("FAIL prescale_stretch_early: count=%0d required 1", count);
    end
    cycle();
    n_tests++;
    if (count !== 8'd2) begin
      n_fail++;
      $display("FAIL prescale_stretch: count=%0d required 2", count);
    end
    $display("[TB] prescale count=%0d", count);
    en = 0;
  endtask
`endif

  task automatic test_random();
    rst_n = 0; cycle(); rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 79) != 0);
      en       = ($urandom_range(0, 3) != 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 31) == 0) limit = W'($urandom_range(0, 12));
      cycle();
      n_tests++;
      if (count !== W'(m_count) || tc !== m_tc[0] || done !== m_done[0]) begin
        n_fail++;
        $display("FAIL random[%0d]: count=%0d tc=%b done=%b required %0d/%0d/%0d",
                 i, count, tc, done, m_count, m_tc, m_done);
      end
      $display("[TB] rnd %0d rst_n=%b en=%b ld=%b ud=%b md=%0d lim=%0d -> count=%0d tc=%b done=%b",
               i, rst_n, en, load, up_dn, mode, limit, count, tc, done);
    end
    rst_n = 1; en = 0; load = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
`ifndef COUNTER_PRESCALE_EN
    test_wrap_up();
    test_saturate_down();
    test_oneshot();
    test_back_to_back();
    test_limit_zero();
`else
    test_prescale();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
